// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, buffers returns in a FIFO for ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module if_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src_in,
    input  logic [31:0] pc_branch_in,
    input  logic        stall_in,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [31:0]   DEPTH_L = 32'(DEPTH);

    logic          r_active;
    logic [31:0]   r_fetch_pc;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_drop;
    logic [31:0]   r_tag [DEPTH];
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic        w_empty;
    logic        w_issue;
    logic        w_drop_rsp;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_used;
    logic        w_unused_lsbs;

    assign w_unused_lsbs = &{1'b0, pc_branch_in[1:0]};

    // Credits count FIFO entries plus live in-flight requests; doomed ones do not hold a slot.
    assign w_used  = 32'(r_count) + 32'(r_out) - 32'(r_drop);
    assign w_empty = (r_count == '0);

    assign imem_req_valid = r_active && !pc_src_in && (r_out < MAX_OUT) && (w_used < DEPTH_L);
    assign imem_req_addr  = r_fetch_pc;
    assign w_issue        = imem_req_valid && imem_req_ready;

    assign w_drop_rsp = imem_rsp_valid && (pc_src_in || (r_drop != '0));
    assign w_push     = imem_rsp_valid && !w_drop_rsp;
    assign w_pop      = !w_empty && !stall_in && !pc_src_in;

    assign id_valid = !w_empty;
    assign id_pc    = w_empty ? 32'd0 : r_fifo_pc[r_rd_ptr];
    assign id_instr = w_empty ? NOP_INSTR : r_fifo_instr[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_active <= 1'b1;

            if (pc_src_in) begin
                r_fetch_pc <= {pc_branch_in[31:2], 2'b00};
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            case ({w_issue, imem_rsp_valid})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase

            // Everything still in flight after a redirect belongs to the old path.
            if (pc_src_in) begin
                r_drop <= imem_rsp_valid ? (r_out - 1'b1) : r_out;
            end else if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end

            if (w_issue) begin
                r_tag_wr <= r_tag_wr + 1'b1;
            end
            if (imem_rsp_valid) begin
                r_tag_rd <= r_tag_rd + 1'b1;
            end

            if (pc_src_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage arrays carry no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched      <= 32'd0;
            perf_dropped      <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (w_push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (w_drop_rsp) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (id_valid && stall_in) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios push expected request addresses and
// deliveries; a monitor process compares them against what the DUT presents.
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_src_in = 1'b0;
    logic [31:0] pc_branch_in = 32'd0;
    logic        stall_in = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall_cycles;
`endif

    if_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .pc_src_in      (pc_src_in),
        .pc_branch_in   (pc_branch_in),
        .stall_in       (stall_in),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_dropped      (perf_dropped),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Stimulus-owned state
    int          lat = 1;
    int          hs_allowed = 0;
    logic [31:0] exp_pc  [256];
    int          exp_wr = 0;
    logic [31:0] req_exp [256];
    int          req_wr = 0;
    string       probe_name = "";
    int          probe_code = 0;
    logic [31:0] probe_exp = 32'd0;
    int          probe_seq = 0;

    // imem-model-owned state
    int          cyc = 0;
    int          hs_done = 0;
    logic        hs = 1'b0;
    logic [31:0] hs_addr = 32'd0;
    logic [31:0] m_addr [256];
    int          m_due  [256];
    int          m_wr = 0;
    int          m_rd = 0;

    // monitor-owned state
    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int req_rd = 0;
    int probe_seen = 0;

    // In-order imem with per-request latency; cleared by the shared reset.
    always begin
        @(negedge clk);
        hs      = reset && imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        @(posedge clk);
        cyc++;
        if (hs) begin
            m_addr[m_wr % 256] = hs_addr;
            m_due[m_wr % 256]  = cyc - 1 + lat;
            m_wr++;
            hs_done++;
        end
        #2;
        if (!reset) m_rd = m_wr;
        if (reset && (m_rd != m_wr) && (m_due[m_rd % 256] <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(m_addr[m_rd % 256]);
            m_rd++;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        imem_req_ready = reset && (hs_done < hs_allowed);
    end

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or negedge reset);
        if (!reset) begin
            #1;
            chk32("rst_id_valid", {31'd0, id_valid}, 32'd0);
            chk32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk32("rst_id_pc", id_pc, 32'd0);
            chk32("rst_id_instr", id_instr, NOP);
            exp_rd = exp_wr;
            req_rd = req_wr;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                if (req_rd == req_wr) begin
                    chk32("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
                end else begin
                    chk32("req_addr", imem_req_addr, req_exp[req_rd % 256]);
                    req_rd++;
                end
            end
            if (id_valid && !pc_src_in) begin
                if (exp_rd == exp_wr) begin
                    chk32("id_unexpected", id_pc, 32'hxxxx_xxxx);
                end else begin
                    chk32("id_pc", id_pc, exp_pc[exp_rd % 256]);
                    chk32("id_instr", id_instr, instr_of(exp_pc[exp_rd % 256]));
                    if (!stall_in) exp_rd++;
                end
            end else if (!id_valid) begin
                chk32("empty_pc", id_pc, 32'd0);
                chk32("empty_instr", id_instr, NOP);
            end
            if (probe_seq != probe_seen) begin
                probe_seen = probe_seq;
                case (probe_code)
                    0: chk32(probe_name, {31'd0, imem_req_valid}, probe_exp);
                    1: chk32(probe_name, {31'd0, id_valid}, probe_exp);
                    2: chk32(probe_name, imem_req_addr, probe_exp);
                    4: chk32(probe_name, 32'((exp_wr - exp_rd) + (req_wr - req_rd)), probe_exp);
`ifdef FETCH_PERF_CNT_EN
                    5: chk32(probe_name, perf_fetched | perf_dropped | perf_stall_cycles, probe_exp);
                    6: chk32(probe_name, perf_dropped, probe_exp);
`endif
                    default: chk32(probe_name, 32'hdead_beef, probe_exp);
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a);
        req_exp[req_wr % 256] = a;
        req_wr++;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_pc[exp_wr % 256] = a;
        exp_wr++;
    endtask

    task automatic probe(input string name, input int code, input logic [31:0] exp);
        probe_name = name;
        probe_code = code;
        probe_exp  = exp;
        probe_seq++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (((exp_rd != exp_wr) || (req_rd != req_wr)) && (n < 100)) begin
            step();
            n++;
        end
        probe(name, 4, 32'd0);
        step();
    endtask

    initial begin
        // 1: reset release, streaming at 1-cycle latency
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        hs_allowed += 3;
        foreach (req_exp[i]) if (i < 3) begin push_req(32'(i * 4)); push_exp(32'(i * 4)); end
        step();
        probe("first_addr", 2, 32'h0);
        step();
        probe("idv_after_1", 1, 32'd0);
        step();
        probe("idv_after_2", 1, 32'd1);
        wait_drain("drain_stream");

        // 2: stall while the FIFO fills
        stall_in = 1'b1;
        hs_allowed += 8;
        for (int i = 0; i < 8; i++) begin
            push_req(32'h0C + 32'(i * 4));
            push_exp(32'h0C + 32'(i * 4));
        end
        repeat (4) step();
        probe("credit_block", 0, 32'd0);
        step();
        stall_in = 1'b0;
        wait_drain("drain_stall");

        // 3: redirect with two requests in flight at latency 3
        lat = 3;
        hs_allowed += 2;
        push_req(32'h2C);
        push_req(32'h30);
        step();
        step();
        pc_src_in    = 1'b1;
        pc_branch_in = 32'h100;
        hs_allowed += 2;
        push_req(32'h100);
        push_req(32'h104);
        push_exp(32'h100);
        push_exp(32'h104);
        step();
        pc_src_in = 1'b0;
        wait_drain("drain_redirect");
`ifdef FETCH_PERF_CNT_EN
        probe("perf_dropped", 6, 32'd2);
        step();
`endif

        // 4: redirect coinciding with a response and a stall; unaligned target
        lat = 2;
        hs_allowed += 1;
        push_req(32'h108);
        step();
        step();
        stall_in     = 1'b1;
        pc_src_in    = 1'b1;
        pc_branch_in = 32'h103;
        hs_allowed += 1;
        push_req(32'h100);
        push_exp(32'h100);
        step();
        pc_src_in = 1'b0;
        stall_in  = 1'b0;
        probe("flush_empty", 1, 32'd0);
        wait_drain("drain_collide");

        // 5: fetch PC wraps past the top of the address space
        lat = 1;
        pc_src_in    = 1'b1;
        pc_branch_in = 32'hFFFF_FFF8;
        hs_allowed += 3;
        push_req(32'hFFFF_FFF8);
        push_req(32'hFFFF_FFFC);
        push_req(32'h0);
        push_exp(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        step();
        pc_src_in = 1'b0;
        wait_drain("drain_wrap");

        // 6: async reset mid-stream, then restart from the reset PC
        stall_in = 1'b1;
        hs_allowed += 1;
        push_req(32'h4);
        push_exp(32'h4);
        step();
        step();
        probe("pre_rst_idv", 1, 32'd1);
        step();
        #3 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        stall_in = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        probe("perf_after_rst", 5, 32'd0);
`endif
        hs_allowed += 2;
        push_req(32'h0);
        push_req(32'h4);
        push_exp(32'h0);
        push_exp(32'h4);
        step();
        wait_drain("drain_restart");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage directly upstream of the decode stage in the 5-stage RISC-V pipeline. It owns the fetch PC and issues in-order requests to instruction memory, which may respond with variable latency. Returned words are buffered in a small FIFO and delivered to ID as PC/instruction pairs. It honours the pipeline stall and redirects on a taken branch or jump (PCSrc), discarding stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum imem requests in flight; 1..DEPTH
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, value driven on id_instr when id_valid=0

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
pc_src_in  in  1  taken branch/jump from EX/MEM (PCSrc); redirect request
pc_branch_in  in  32  redirect target, sampled when pc_src_in=1
stall_in  in  1  pipeline_stall from hazard unit; ID cannot accept an instruction
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  32  fetch address (word-aligned)
imem_rsp_valid  in  1  response data valid; responses return in request order
imem_rsp_data  in  32  instruction word
id_valid  out  1  id_pc/id_instr hold a valid instruction
id_pc  out  32  PC of delivered instruction
id_instr  out  32  delivered instruction

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: id_valid=0, id_pc=0, id_instr=NOP_INSTR, imem_req_valid=0, imem_req_addr=RESET_PC.
- Request issue: imem_req_valid = !pc_src_in && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding-drop_cnt)<DEPTH. imem_req_addr=fetch_pc. On valid&&ready: fetch_pc += 4 (mod 2^32), outstanding++, and the request's PC is pushed into an in-flight PC tag queue.
- Response: each imem_rsp_valid decrements outstanding and pops the tag queue. If drop_cnt>0, the response is discarded and drop_cnt--. Otherwise {tag PC, data} is written into the FIFO. Response-to-id_valid latency is 1 cycle. The credit rule above guarantees the FIFO never overflows. Simultaneous issue and response in one cycle is legal; outstanding is unchanged.
- Delivery: id_valid = FIFO non-empty. id_pc/id_instr show the FIFO head and are combinational from the head entry. Pop when id_valid && !stall_in. While stalled, the head is held stable. When the FIFO is empty: id_pc=0, id_instr=NOP_INSTR.
- Redirect (pc_src_in=1) overrides stall and all other activity in that cycle:
  - FIFO flushed and no pop counted.
  - No request issued.
  - A response arriving in this cycle is discarded.
  - drop_cnt <= outstanding minus any response received this cycle.
  - fetch_pc <= {pc_branch_in[31:2],2'b00}.
  - Requests from the target begin the following cycle.
- Back-to-back redirects: the second overrides the first. drop_cnt is recomputed as all still-outstanding requests.
- Full FIFO: no issue until space is available. Outputs are unaffected.
- Reset asserted mid-transaction clears everything. imem is expected to be reset by the same signal, so no stale responses arrive after release.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds three outputs, each 32-bit and wrapping:
- perf_fetched: count of FIFO writes.
- perf_dropped: count of discarded responses, including responses discarded in a redirect cycle.
- perf_stall_cycles: count of cycles with id_valid && stall_in.
All three reset to 0. When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset release, imem ready always, 1-cycle response latency, no stall -> requests to 0x0, 0x4, 0x8 on consecutive cycles; id_valid first high 2 cycles after the first handshake, with id_pc=0x0 and the matching instr, then one instruction per cycle.
- stall_in high for 5 cycles with the FIFO filling -> id_pc held constant; at most DEPTH entries plus in-flight requests; imem_req_valid drops when credits are exhausted; no loss or duplication after release.
- Two requests outstanding at 3-cycle latency, then pc_src_in=1 with pc_branch_in=0x100 -> both old responses dropped; next id_valid shows id_pc=0x100.
- Redirect in the same cycle as imem_rsp_valid and stall_in -> response discarded, FIFO empty next cycle, next request address 0x100.
- fetch_pc near 0xFFFFFFFC -> next address wraps to 0x00000000.
- Async reset asserted mid-stream (not aligned to clk) -> id_valid=0 and imem_req_valid=0 immediately; fetch restarts at RESET_PC after release. With FETCH_PERF_CNT_EN defined, counters read 0 after reset and perf_dropped=2 after the redirect scenario.
